// File: rtl/dmem_port_arbiter_if.sv
// Request, response and data-memory signals shared by the two requesters,
// the arbiter and the dmem macro.
interface dmem_port_arbiter_if #(
    parameter int N = 64
);
    logic         p0_valid;
    logic         p0_ready;
    logic         p0_write;
    logic [10:0]  p0_addr;
    logic [2:0]   p0_width;
    logic [N-1:0] p0_wdata;
    logic         p0_resp_valid;
    logic [N-1:0] p0_resp_rdata;
    logic         p0_resp_err;

    logic         p1_valid;
    logic         p1_ready;
    logic         p1_write;
    logic [10:0]  p1_addr;
    logic [2:0]   p1_width;
    logic [N-1:0] p1_wdata;
    logic         p1_resp_valid;
    logic [N-1:0] p1_resp_rdata;
    logic         p1_resp_err;

    logic [N-1:0] DM_writeData;
    logic [7:0]   wordAddr;
    logic         readEnable;
    logic         writeEnable;
    logic [2:0]   memWidth;
    logic [2:0]   byteOffset;
    logic [N-1:0] DM_readData;

    // Arbiter view: takes requests and memory read data, drives everything else
    modport slave (
        input  p0_valid, p0_write, p0_addr, p0_width, p0_wdata,
        output p0_ready, p0_resp_valid, p0_resp_rdata, p0_resp_err,
        input  p1_valid, p1_write, p1_addr, p1_width, p1_wdata,
        output p1_ready, p1_resp_valid, p1_resp_rdata, p1_resp_err,
        output DM_writeData, wordAddr, readEnable, writeEnable, memWidth, byteOffset,
        input  DM_readData
    );

    modport master (
        output p0_valid, p0_write, p0_addr, p0_width, p0_wdata,
        input  p0_ready, p0_resp_valid, p0_resp_rdata, p0_resp_err,
        output p1_valid, p1_write, p1_addr, p1_width, p1_wdata,
        input  p1_ready, p1_resp_valid, p1_resp_rdata, p1_resp_err,
        input  DM_writeData, wordAddr, readEnable, writeEnable, memWidth, byteOffset,
        output DM_readData
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single 64-bit data memory: fixed priority with
// anti-starvation for port 1, store lane alignment and 1-cycle load extraction.
module dmem_port_arbiter #(
    parameter int N            = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    dmem_port_arbiter_if.slave  bus
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]   r_starve;
    logic         r_valid;
    logic         r_port;
    logic         r_write;
    logic [2:0]   r_width;
    logic [2:0]   r_off;
    logic         r_err;

    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_any;
    logic         w_write;
    logic [10:0]  w_addr;
    logic [2:0]   w_width;
    logic [N-1:0] w_wdata;
    logic         w_err;
    logic [N-1:0] w_shift;
    logic [N-1:0] w_ext;
    logic [N-1:0] w_rdata;

    // Port 1 overtakes port 0 only once it has been refused STARVE_LIMIT times in a row
    always_comb begin
        w_gnt1  = reset_n && bus.p1_valid && (!bus.p0_valid || (r_starve == LIMIT));
        w_gnt0  = reset_n && bus.p0_valid && !w_gnt1;
        w_any   = w_gnt0 || w_gnt1;
        w_write = w_gnt1 ? bus.p1_write : bus.p0_write;
        w_addr  = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
        w_width = w_gnt1 ? bus.p1_width : bus.p0_width;
        w_wdata = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;
    end

    always_comb begin
        w_err = 1'b0;
        case (w_width)
            3'b000, 3'b100: w_err = 1'b0;
            3'b001, 3'b101: w_err = w_addr[0];
            3'b010, 3'b110: w_err = |w_addr[1:0];
            3'b011:         w_err = |w_addr[2:0];
            default:        w_err = 1'b1;
        endcase
    end

    // Errored requests are still accepted but never touch the memory
    always_comb begin
        bus.DM_writeData = '0;
        bus.wordAddr     = '0;
        bus.readEnable   = 1'b0;
        bus.writeEnable  = 1'b0;
        bus.memWidth     = '0;
        bus.byteOffset   = '0;
        if (w_any && !w_err) begin
            bus.DM_writeData = w_wdata << {w_addr[2:0], 3'b000};
            bus.wordAddr     = w_addr[10:3];
            bus.readEnable   = !w_write;
            bus.writeEnable  = w_write;
            bus.memWidth     = w_width;
            bus.byteOffset   = w_addr[2:0];
        end
    end

    assign bus.p0_ready = w_gnt0;
    assign bus.p1_ready = w_gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (bus.p1_valid && !w_gnt1) begin
            if (r_starve != LIMIT) begin
                r_starve <= r_starve + 3'd1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_port  <= 1'b0;
            r_write <= 1'b0;
            r_width <= '0;
            r_off   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_port  <= w_gnt1;
                r_write <= w_write;
                r_width <= w_width;
                r_off   <= w_addr[2:0];
                r_err   <= w_err;
            end
        end
    end

    // Bring the addressed lane down to bit 0, then extend from the access size
    always_comb begin
        w_shift = bus.DM_readData >> {r_off, 3'b000};
        w_ext   = '0;
        case (r_width)
            3'b000:  w_ext = {{(N-8){w_shift[7]}},   w_shift[7:0]};
            3'b001:  w_ext = {{(N-16){w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_ext = {{(N-32){w_shift[31]}}, w_shift[31:0]};
            3'b011:  w_ext = w_shift;
            3'b100:  w_ext = {{(N-8){1'b0}},  w_shift[7:0]};
            3'b101:  w_ext = {{(N-16){1'b0}}, w_shift[15:0]};
            3'b110:  w_ext = {{(N-32){1'b0}}, w_shift[31:0]};
            default: w_ext = '0;
        endcase
        w_rdata = (r_valid && !r_write && !r_err) ? w_ext : '0;
    end

    assign bus.p0_resp_valid = r_valid && !r_port;
    assign bus.p1_resp_valid = r_valid && r_port;
    assign bus.p0_resp_rdata = bus.p0_resp_valid ? w_rdata : '0;
    assign bus.p1_resp_rdata = bus.p1_resp_valid ? w_rdata : '0;
    assign bus.p0_resp_err   = bus.p0_resp_valid && r_err;
    assign bus.p1_resp_err   = bus.p1_resp_valid && r_err;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural dmem, a byte-level reference memory
// and grant model feeding a response scoreboard, plus directed scenario tasks.
module tb_dmem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic        port;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    exp_t        expQ[$];
    logic [7:0]  refMem[0:2047];
    logic        refCleared;
    logic [63:0] dmMem[0:255];
    logic        memCleared;

    int          mStarve;
    logic        mG0;
    logic        mG1;
    logic        mW;
    logic [10:0] mA;
    logic [2:0]  mWd;
    logic [63:0] mD;
    logic        mErr;
    logic [63:0] mShifted;
    exp_t        e;

    dmem_port_arbiter_if #(.N(64)) bus ();

    dmem_port_arbiter #(
        .N            (64),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Behavioural dmem: per-byte write enables, synchronous read
    always @(posedge clk) begin
        if (!memCleared) begin
            for (int i = 0; i < 256; i++) dmMem[i] <= '0;
            memCleared <= 1'b1;
        end else begin
            if (bus.writeEnable) begin
                for (int i = 0; i < 8; i++) begin
                    if (i >= int'(bus.byteOffset) &&
                        i < int'(bus.byteOffset) + (1 << bus.memWidth[1:0]))
                        dmMem[bus.wordAddr][8*i +: 8] <= bus.DM_writeData[8*i +: 8];
                end
            end
            if (bus.readEnable) bus.DM_readData <= dmMem[bus.wordAddr];
        end
    end

    function automatic logic refErr(input logic [2:0] w, input logic [10:0] a);
        int sz;
        if (w == 3'b111) return 1'b1;
        sz = 1 << w[1:0];
        return (int'(a) % sz) != 0;
    endfunction

    function automatic logic [63:0] refLoad(input logic [2:0] w, input logic [10:0] a);
        logic [63:0] v;
        int sz;
        v  = '0;
        sz = 1 << w[1:0];
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refMem[int'(a) + i];
        if (!w[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
        return v;
    endfunction

    // Scoreboard: sampled just before each rising edge
    always @(negedge clk) begin
        #4;
        if (!reset_n) begin
            if (!refCleared) begin
                for (int i = 0; i < 2048; i++) refMem[i] = '0;
                refCleared = 1'b1;
            end
            checks++;
            if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0)
                $display("[TB] FAIL reset_ready: got p0=%b p1=%b want 0 0", bus.p0_ready, bus.p1_ready);
            checks++;
            if (bus.readEnable !== 1'b0 || bus.writeEnable !== 1'b0)
                $display("[TB] FAIL reset_enables: got re=%b we=%b want 0 0", bus.readEnable, bus.writeEnable);
            checks++;
            if (bus.p0_resp_valid !== 1'b0 || bus.p1_resp_valid !== 1'b0)
                $display("[TB] FAIL reset_resp: got v0=%b v1=%b want 0 0", bus.p0_resp_valid, bus.p1_resp_valid);
            if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0) errors++;
            if (bus.readEnable !== 1'b0 || bus.writeEnable !== 1'b0) errors++;
            if (bus.p0_resp_valid !== 1'b0 || bus.p1_resp_valid !== 1'b0) errors++;
            expQ.delete();
            mStarve = 0;
        end else begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if (bus.p0_resp_valid !== !e.port || bus.p1_resp_valid !== e.port) begin
                    errors++;
                    $display("[TB] FAIL sb_route: got v0=%b v1=%b want port %0d", bus.p0_resp_valid, bus.p1_resp_valid, e.port);
                end
                checks++;
                if ((e.port ? bus.p1_resp_rdata : bus.p0_resp_rdata) !== e.rdata) begin
                    errors++;
                    $display("[TB] FAIL sb_rdata: got %h want %h", e.port ? bus.p1_resp_rdata : bus.p0_resp_rdata, e.rdata);
                end
                checks++;
                if ((e.port ? bus.p1_resp_err : bus.p0_resp_err) !== e.err) begin
                    errors++;
                    $display("[TB] FAIL sb_err: got %b want %b", e.port ? bus.p1_resp_err : bus.p0_resp_err, e.err);
                end
            end else begin
                checks++;
                if (bus.p0_resp_valid !== 1'b0 || bus.p1_resp_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sb_spurious: got v0=%b v1=%b want 0 0", bus.p0_resp_valid, bus.p1_resp_valid);
                end
            end

            mG1 = bus.p1_valid && (!bus.p0_valid || mStarve >= STARVE_LIMIT);
            mG0 = bus.p0_valid && !mG1;
            checks++;
            if (bus.p0_ready !== mG0 || bus.p1_ready !== mG1) begin
                errors++;
                $display("[TB] FAIL sb_grant: got p0=%b p1=%b want %b %b", bus.p0_ready, bus.p1_ready, mG0, mG1);
            end

            if (mG0 || mG1) begin
                mW   = mG1 ? bus.p1_write : bus.p0_write;
                mA   = mG1 ? bus.p1_addr  : bus.p0_addr;
                mWd  = mG1 ? bus.p1_width : bus.p0_width;
                mD   = mG1 ? bus.p1_wdata : bus.p0_wdata;
                mErr = refErr(mWd, mA);
                checks++;
                if (bus.readEnable !== (!mErr && !mW) || bus.writeEnable !== (!mErr && mW)) begin
                    errors++;
                    $display("[TB] FAIL sb_enables: got re=%b we=%b want %b %b", bus.readEnable, bus.writeEnable, !mErr && !mW, !mErr && mW);
                end
                if (!mErr) begin
                    checks++;
                    if (bus.wordAddr !== mA[10:3] || bus.byteOffset !== mA[2:0] || bus.memWidth !== mWd) begin
                        errors++;
                        $display("[TB] FAIL sb_addr: got wa=%h off=%0d w=%0d want %h %0d %0d", bus.wordAddr, bus.byteOffset, bus.memWidth, mA[10:3], mA[2:0], mWd);
                    end
                    if (mW) begin
                        mShifted = '0;
                        for (int i = 0; i < 8; i++)
                            if (i + int'(mA[2:0]) < 8) mShifted[8*(i + int'(mA[2:0])) +: 8] = mD[8*i +: 8];
                        checks++;
                        if (bus.DM_writeData !== mShifted) begin
                            errors++;
                            $display("[TB] FAIL sb_wdata: got %h want %h", bus.DM_writeData, mShifted);
                        end
                        for (int i = 0; i < (1 << mWd[1:0]); i++) refMem[int'(mA) + i] = mD[8*i +: 8];
                    end
                end
                e.port  = mG1;
                e.err   = mErr;
                e.rdata = (mW || mErr) ? 64'd0 : refLoad(mWd, mA);
                expQ.push_back(e);
            end else begin
                checks++;
                if (bus.readEnable !== 1'b0 || bus.writeEnable !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sb_idle_enables: got re=%b we=%b want 0 0", bus.readEnable, bus.writeEnable);
                end
            end

            if (bus.p1_valid && !mG1) mStarve = (mStarve < STARVE_LIMIT) ? mStarve + 1 : mStarve;
            else                      mStarve = 0;
        end
    end

    task automatic applyStimulus(input int port, input logic w, input logic [10:0] a,
                                 input logic [2:0] wd, input logic [63:0] d);
        if (port == 0) begin
            bus.p0_valid = 1'b1; bus.p0_write = w; bus.p0_addr = a; bus.p0_width = wd; bus.p0_wdata = d;
        end else begin
            bus.p1_valid = 1'b1; bus.p1_write = w; bus.p1_addr = a; bus.p1_width = wd; bus.p1_wdata = d;
        end
    endtask

    task automatic idle();
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        applyStimulus(0, 1'b0, 11'h010, 3'b011, 64'd0);
        repeat (2) begin
            @(negedge clk); #4;
            checks++;
            if (bus.p0_ready !== 1'b0 || bus.readEnable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_issue: got ready=%b re=%b want 0 0", bus.p0_ready, bus.readEnable);
            end
            checks++;
            if (bus.p0_resp_valid !== 1'b0 || bus.p0_resp_rdata !== 64'd0) begin
                errors++;
                $display("[TB] FAIL rst_resp: got v=%b d=%h want 0 0", bus.p0_resp_valid, bus.p0_resp_rdata);
            end
        end
        @(negedge clk);
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_store_load_d();
        @(negedge clk); idle(); applyStimulus(0, 1'b1, 11'h010, 3'b011, 64'h1122334455667788); #4;
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.writeEnable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL d_store_issue: got ready=%b we=%b want 1 1", bus.p0_ready, bus.writeEnable);
        end
        @(negedge clk); idle(); applyStimulus(0, 1'b0, 11'h010, 3'b011, 64'd0); #4;
        checks++;
        if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_rdata !== 64'd0) begin
            errors++;
            $display("[TB] FAIL d_store_resp: got v=%b d=%h want 1 0", bus.p0_resp_valid, bus.p0_resp_rdata);
        end
        @(negedge clk); idle(); #4;
        checks++;
        if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_rdata !== 64'h1122334455667788 || bus.p0_resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL d_load_resp: got v=%b d=%h e=%b want 1 1122334455667788 0", bus.p0_resp_valid, bus.p0_resp_rdata, bus.p0_resp_err);
        end
    endtask

    task automatic test_byte_lanes();
        @(negedge clk); idle(); applyStimulus(0, 1'b1, 11'h013, 3'b000, 64'h80); #4;
        checks++;
        if (bus.DM_writeData !== 64'h80000000 || bus.byteOffset !== 3'd3) begin
            errors++;
            $display("[TB] FAIL byte_store: got wd=%h off=%0d want 80000000 3", bus.DM_writeData, bus.byteOffset);
        end
        @(negedge clk); idle(); applyStimulus(0, 1'b0, 11'h013, 3'b000, 64'd0);
        @(negedge clk); idle(); applyStimulus(0, 1'b0, 11'h013, 3'b100, 64'd0); #4;
        checks++;
        if (bus.p0_resp_rdata !== 64'hFFFFFFFFFFFFFF80) begin
            errors++;
            $display("[TB] FAIL byte_load_b: got %h want ffffffffffffff80", bus.p0_resp_rdata);
        end
        @(negedge clk); idle(); #4;
        checks++;
        if (bus.p0_resp_rdata !== 64'h80) begin
            errors++;
            $display("[TB] FAIL byte_load_bu: got %h want 80", bus.p0_resp_rdata);
        end
    endtask

    task automatic test_errors();
        @(negedge clk); idle(); applyStimulus(0, 1'b0, 11'h001, 3'b001, 64'd0); #4;
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.readEnable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_misalign_issue: got ready=%b re=%b want 1 0", bus.p0_ready, bus.readEnable);
        end
        @(negedge clk); idle(); applyStimulus(0, 1'b0, 11'h000, 3'b111, 64'd0); #4;
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.readEnable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_width_issue: got ready=%b re=%b want 1 0", bus.p0_ready, bus.readEnable);
        end
        checks++;
        if (bus.p0_resp_err !== 1'b1 || bus.p0_resp_rdata !== 64'd0) begin
            errors++;
            $display("[TB] FAIL err_misalign_resp: got e=%b d=%h want 1 0", bus.p0_resp_err, bus.p0_resp_rdata);
        end
        @(negedge clk); idle(); #4;
        checks++;
        if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_err !== 1'b1 || bus.p0_resp_rdata !== 64'd0) begin
            errors++;
            $display("[TB] FAIL err_width_resp: got v=%b e=%b d=%h want 1 1 0", bus.p0_resp_valid, bus.p0_resp_err, bus.p0_resp_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [1:0] want;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); idle();
            applyStimulus(0, 1'b0, 11'h010, 3'b011, 64'd0);
            applyStimulus(1, 1'b0, 11'h008, 3'b011, 64'd0);
            #4;
            want = (k == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.p1_ready, bus.p0_ready} !== want) begin
                errors++;
                $display("[TB] FAIL starve_grant%0d: got p1p0=%b want %b", k, {bus.p1_ready, bus.p0_ready}, want);
            end
            if (k == 5) begin
                checks++;
                if (bus.p1_resp_valid !== 1'b1 || bus.p0_resp_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL starve_route: got v0=%b v1=%b want 0 1", bus.p0_resp_valid, bus.p1_resp_valid);
                end
            end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_back_to_back();
        logic [63:0] want;
        @(negedge clk); idle(); applyStimulus(1, 1'b1, 11'h008, 3'b011, 64'h8000000000000000);
        @(negedge clk); idle(); applyStimulus(0, 1'b1, 11'h000, 3'b010, 64'h80000000);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); idle();
            if (i < 8) begin
                if (i % 2 == 0) applyStimulus(0, 1'b0, 11'h000, 3'b010, 64'd0);
                else            applyStimulus(1, 1'b0, (i % 4 == 1) ? 11'h00C : 11'h008, 3'b110, 64'd0);
            end
            #4;
            if (i > 0) begin
                if ((i - 1) % 2 == 0) want = 64'hFFFFFFFF80000000;
                else                  want = ((i - 1) % 4 == 1) ? 64'h80000000 : 64'd0;
                checks++;
                if ((i - 1) % 2 == 0) begin
                    if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_rdata !== want) begin
                        errors++;
                        $display("[TB] FAIL b2b_p0_%0d: got v=%b d=%h want 1 %h", i, bus.p0_resp_valid, bus.p0_resp_rdata, want);
                    end
                end else begin
                    if (bus.p1_resp_valid !== 1'b1 || bus.p1_resp_rdata !== want) begin
                        errors++;
                        $display("[TB] FAIL b2b_p1_%0d: got v=%b d=%h want 1 %h", i, bus.p1_resp_valid, bus.p1_resp_rdata, want);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] want;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle();
            applyStimulus(0, 1'b0, 11'h010, 3'b011, 64'd0);
            applyStimulus(1, 1'b0, 11'h008, 3'b011, 64'd0);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); reset_n = 1'b0; #4;
            checks++;
            if (bus.p0_resp_valid !== 1'b0 || bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0 || bus.readEnable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_%0d: got v0=%b r0=%b r1=%b re=%b want 0 0 0 0", k, bus.p0_resp_valid, bus.p0_ready, bus.p1_ready, bus.readEnable);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); reset_n = 1'b1; #4;
            want = (k == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.p1_ready, bus.p0_ready} !== want) begin
                errors++;
                $display("[TB] FAIL midrst_grant%0d: got p1p0=%b want %b", k, {bus.p1_ready, bus.p0_ready}, want);
            end
            if (k == 0) begin
                checks++;
                if (bus.p0_resp_valid !== 1'b0 || bus.p1_resp_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midrst_lost_resp: got v0=%b v1=%b want 0 0", bus.p0_resp_valid, bus.p1_resp_valid);
                end
            end
        end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        mStarve       = 0;
        refCleared    = 1'b0;
        memCleared    = 1'b0;
        reset_n       = 1'b0;
        bus.p0_valid  = 1'b0; bus.p0_write = 1'b0; bus.p0_addr = '0; bus.p0_width = '0; bus.p0_wdata = '0;
        bus.p1_valid  = 1'b0; bus.p1_write = 1'b0; bus.p1_addr = '0; bus.p1_width = '0; bus.p1_wdata = '0;
        test_reset();
        test_store_load_d();
        test_byte_lanes();
        test_errors();
        test_starvation();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
